// File: rtl/rr_output_arbiter_if.sv
// ---------------------------------------------------------------------------
// rr_output_arbiter_if
// Handshake bundle between the input buffers / downstream sink and one
// output-port arbiter of the NoC switch.
//   req_i       : per-input request, bit i high while input i holds a flit
//   last_i      : per-input tail marker for the flit currently offered
//   rdy_i       : downstream can accept a flit this cycle
//   grant_o     : index of the locked input (crossbar select)
//   grant_oh_o  : one-hot grant, all zero when not locked
//   grant_vld_o : a grant is currently held
//   xfer_o      : a flit moves this cycle
//   pkt_done_o  : the tail flit moves this cycle
// Modports: master = requester/sink side, slave = arbiter side.
// ---------------------------------------------------------------------------
interface rr_output_arbiter_if #(
    parameter int IN_N = 5
);
    localparam int IDX_W = $clog2(IN_N);

    logic [IN_N-1:0]  req_i;
    logic [IN_N-1:0]  last_i;
    logic             rdy_i;
    logic [IDX_W-1:0] grant_o;
    logic [IN_N-1:0]  grant_oh_o;
    logic             grant_vld_o;
    logic             xfer_o;
    logic             pkt_done_o;

    modport master (
        output req_i, last_i, rdy_i,
        input  grant_o, grant_oh_o, grant_vld_o, xfer_o, pkt_done_o
    );

    modport slave (
        input  req_i, last_i, rdy_i,
        output grant_o, grant_oh_o, grant_vld_o, xfer_o, pkt_done_o
    );
endinterface

// File: rtl/rr_output_arbiter.sv
// ---------------------------------------------------------------------------
// rr_output_arbiter
// Round-robin packet arbiter for one NoC output port. A winner is picked in
// IDLE, then the grant is locked until that input's tail flit transfers
// (wormhole lock). The priority pointer only moves on packet completion.
// Ports:
//   clk_i  : clock, rising edge
//   rst_i  : synchronous active-high reset
//   arbBus : rr_output_arbiter_if.slave (requests, tails, ready, grants,
//            transfer strobes)
// ---------------------------------------------------------------------------
module rr_output_arbiter #(
    parameter int IN_N = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    rr_output_arbiter_if.slave arbBus
);
    localparam int IDX_W = $clog2(IN_N);

    typedef enum logic {
        IDLE,
        LOCKED
    } state_t;

    state_t           r_state;
    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W-1:0] r_grant;
    logic [IN_N-1:0]  r_grantOh;
    logic             r_grantVld;

    logic             w_anyReq;
    logic [IDX_W-1:0] w_winner;
    logic [IDX_W-1:0] w_idx;
    logic [IDX_W-1:0] w_nextPtr;
    logic             w_xfer;
    logic             w_pktDone;

    // Round-robin search: walk the inputs starting at the pointer, wrapping
    // explicitly at IN_N so non-power-of-two port counts never see a phantom
    // index. The first requester found in that order wins.
    always_comb begin
        int idx;
        w_anyReq = 1'b0;
        w_winner = '0;
        w_idx    = '0;
        idx      = 0;
        for (int k = 0; k < IN_N; k++) begin
            idx = int'(r_ptr) + k;
            if (idx >= IN_N) begin
                idx = idx - IN_N;
            end
            w_idx = IDX_W'(idx);
            if (!w_anyReq && arbBus.req_i[w_idx]) begin
                w_anyReq = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    // Pointer after a completed packet: the input just served drops to
    // lowest priority, with an explicit wrap from IN_N-1 back to 0.
    always_comb begin
        if (r_grant == IDX_W'(IN_N - 1)) begin
            w_nextPtr = '0;
        end else begin
            w_nextPtr = r_grant + 1'b1;
        end
    end

    // Transfer strobes are combinational so the downstream sees them in the
    // same cycle the flit moves. Tail markers only matter on a transfer.
    always_comb begin
        w_xfer    = r_grantVld & arbBus.rdy_i & arbBus.req_i[r_grant];
        w_pktDone = w_xfer & arbBus.last_i[r_grant];
    end

    // Arbitration FSM. IDLE registers the winner (one cycle of arbitration
    // latency); LOCKED holds the grant through bubbles and stalls and only
    // releases on the tail transfer. grant keeps its last value when released.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= IDLE;
            r_ptr      <= '0;
            r_grant    <= '0;
            r_grantOh  <= '0;
            r_grantVld <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_anyReq) begin
                        r_state    <= LOCKED;
                        r_grant    <= w_winner;
                        r_grantOh  <= IN_N'(1) << w_winner;
                        r_grantVld <= 1'b1;
                    end
                end
                LOCKED: begin
                    if (w_pktDone) begin
                        r_state    <= IDLE;
                        r_grantOh  <= '0;
                        r_grantVld <= 1'b0;
                        r_ptr      <= w_nextPtr;
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_grantOh  <= '0;
                    r_grantVld <= 1'b0;
                end
            endcase
        end
    end

    // Drive the bundle outputs from the registered grant path.
    always_comb begin
        arbBus.grant_o     = r_grant;
        arbBus.grant_oh_o  = r_grantOh;
        arbBus.grant_vld_o = r_grantVld;
        arbBus.xfer_o      = w_xfer;
        arbBus.pkt_done_o  = w_pktDone;
    end
endmodule

// File: tb/tb_rr_output_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rr_output_arbiter
// Self-checking bench for rr_output_arbiter: a directed vector table,
// hand-written multi-cycle sequences, and a randomized run compared against
// a behavioural round-robin model. A second instance with IN_N=3 checks the
// wrap on a smaller port count.
// ---------------------------------------------------------------------------
module tb_rr_output_arbiter;
    localparam int N = 5;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    rr_output_arbiter_if #(.IN_N(N)) arb ();
    rr_output_arbiter_if #(.IN_N(3)) arb3 ();

    rr_output_arbiter #(.IN_N(N)) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .arbBus (arb.slave)
    );

    rr_output_arbiter #(.IN_N(3)) dut3 (
        .clk_i  (clk),
        .rst_i  (rst),
        .arbBus (arb3.slave)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [N-1:0] req;
        logic [N-1:0] last;
        logic         rdy;
        logic         expVld;
        int           expGrant;
        logic         expXfer;
        logic         expDone;
    } vec_t;

    vec_t vecs[13];

    // Behavioural model state: lock flag, locked input, priority pointer.
    bit mLocked;
    int mGrant;
    int mPtr;

    // First requester in circular order starting at p, or -1 if none.
    function automatic int pickWinner(logic [N-1:0] r, int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic modelReset();
        mLocked = 1'b0;
        mGrant  = 0;
        mPtr    = 0;
    endtask

    task automatic modelStep(logic r, logic [N-1:0] q, logic [N-1:0] l, logic rd);
        int w;
        if (r) begin
            modelReset();
        end else if (!mLocked) begin
            w = pickWinner(q, mPtr);
            if (w >= 0) begin
                mLocked = 1'b1;
                mGrant  = w;
            end
        end else if (rd && q[mGrant] && l[mGrant]) begin
            mLocked = 1'b0;
            mPtr    = (mGrant + 1) % N;
        end
    endtask

    task automatic checkOutput(string name, int actual, int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic checkAll(string tag, logic expVld, int expGrant, logic expXfer, logic expDone);
        logic [N-1:0] expOh;
        expOh = expVld ? (N'(1) << expGrant) : '0;
        checkOutput({tag, ".vld"},  int'(arb.grant_vld_o), int'(expVld));
        checkOutput({tag, ".grant"}, int'(arb.grant_o),    expGrant);
        checkOutput({tag, ".oh"},   int'(arb.grant_oh_o),  int'(expOh));
        checkOutput({tag, ".xfer"}, int'(arb.xfer_o),      int'(expXfer));
        checkOutput({tag, ".done"}, int'(arb.pkt_done_o),  int'(expDone));
    endtask

    task automatic applyStimulus(logic [N-1:0] q, logic [N-1:0] l, logic rd);
        arb.req_i  = q;
        arb.last_i = l;
        arb.rdy_i  = rd;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst = 1'b1;
        arb.req_i   = '0;
        arb.last_i  = '0;
        arb.rdy_i   = 1'b0;
        tick();
        rst = 1'b0;
        modelReset();
    endtask

    // Structural invariants of the grant path, sampled mid-cycle.
    bit           started;
    logic         prevVld;
    logic [2:0]   prevGrant;
    always @(negedge clk) begin
        if (started) begin
            checks++;
            if ($countones(arb.grant_oh_o) > 1) begin
                errors++;
                $display("[TB] FAIL inv.onehot: got %b, expected one-hot or zero", arb.grant_oh_o);
            end
            checks++;
            if (arb.grant_oh_o[arb.grant_o] !== arb.grant_vld_o) begin
                errors++;
                $display("[TB] FAIL inv.ohIdx: got %b, expected %b", arb.grant_oh_o[arb.grant_o], arb.grant_vld_o);
            end
            if (prevVld && arb.grant_vld_o) begin
                checks++;
                if (arb.grant_o !== prevGrant) begin
                    errors++;
                    $display("[TB] FAIL inv.stable: got %0d, expected %0d", arb.grant_o, prevGrant);
                end
            end
            prevVld   = arb.grant_vld_o;
            prevGrant = arb.grant_o;
        end
    end

    initial begin
        checks     = 0;
        errors     = 0;
        started    = 1'b0;
        prevVld    = 1'b0;
        prevGrant  = '0;
        rst        = 1'b0;
        arb3.req_i  = '0;
        arb3.last_i = '0;
        arb3.rdy_i  = 1'b0;

        // Alternation between inputs 2 and 4, multi-flit then single-flit,
        // including a grant taken while downstream is not ready.
        vecs[0]  = '{5'b10100, 5'b00000, 1'b1, 1'b0, 0, 1'b0, 1'b0};
        vecs[1]  = '{5'b10100, 5'b00000, 1'b1, 1'b1, 2, 1'b1, 1'b0};
        vecs[2]  = '{5'b10100, 5'b00000, 1'b1, 1'b1, 2, 1'b1, 1'b0};
        vecs[3]  = '{5'b10100, 5'b00100, 1'b1, 1'b1, 2, 1'b1, 1'b1};
        vecs[4]  = '{5'b10100, 5'b00000, 1'b1, 1'b0, 2, 1'b0, 1'b0};
        vecs[5]  = '{5'b10100, 5'b10000, 1'b1, 1'b1, 4, 1'b1, 1'b1};
        vecs[6]  = '{5'b10100, 5'b00000, 1'b1, 1'b0, 4, 1'b0, 1'b0};
        vecs[7]  = '{5'b10100, 5'b00100, 1'b1, 1'b1, 2, 1'b1, 1'b1};
        vecs[8]  = '{5'b10100, 5'b00000, 1'b0, 1'b0, 2, 1'b0, 1'b0};
        vecs[9]  = '{5'b10100, 5'b10000, 1'b0, 1'b1, 4, 1'b0, 1'b0};
        vecs[10] = '{5'b10100, 5'b10000, 1'b1, 1'b1, 4, 1'b1, 1'b1};
        vecs[11] = '{5'b00000, 5'b00000, 1'b1, 1'b0, 4, 1'b0, 1'b0};
        vecs[12] = '{5'b00000, 5'b00000, 1'b1, 1'b0, 4, 1'b0, 1'b0};

        // Reset state.
        doReset();
        started = 1'b1;
        applyStimulus('0, '0, 1'b0);
        checkAll("reset", 1'b0, 0, 1'b0, 1'b0);

        // Directed vector table.
        for (int i = 0; i < 13; i++) begin
            applyStimulus(vecs[i].req, vecs[i].last, vecs[i].rdy);
            checkAll($sformatf("vec%0d", i), vecs[i].expVld, vecs[i].expGrant,
                     vecs[i].expXfer, vecs[i].expDone);
            tick();
        end

        // Lock hold: input 1 bubbles and downstream stalls while input 0 waits.
        doReset();
        applyStimulus(5'b00010, 5'b00000, 1'b1);
        checkAll("hold.arb", 1'b0, 0, 1'b0, 1'b0);
        tick();
        applyStimulus(5'b00011, 5'b00000, 1'b1);
        checkAll("hold.f1", 1'b1, 1, 1'b1, 1'b0);
        tick();
        applyStimulus(5'b00001, 5'b00000, 1'b0);
        checkAll("hold.bub1", 1'b1, 1, 1'b0, 1'b0);
        tick();
        applyStimulus(5'b00001, 5'b00010, 1'b1);
        checkAll("hold.bub2", 1'b1, 1, 1'b0, 1'b0);
        tick();
        applyStimulus(5'b00011, 5'b00010, 1'b0);
        checkAll("hold.stall", 1'b1, 1, 1'b0, 1'b0);
        tick();
        applyStimulus(5'b00011, 5'b00010, 1'b1);
        checkAll("hold.tail", 1'b1, 1, 1'b1, 1'b1);
        tick();
        applyStimulus(5'b00001, 5'b00000, 1'b1);
        checkAll("hold.idle", 1'b0, 1, 1'b0, 1'b0);
        tick();
        applyStimulus(5'b00001, 5'b00000, 1'b1);
        checkAll("hold.next", 1'b1, 0, 1'b1, 1'b0);
        tick();

        // Single-flit packets from every input on both instances: grants
        // rotate with one idle cycle in between and wrap back to 0.
        doReset();
        arb3.req_i  = 3'b111;
        arb3.last_i = 3'b111;
        arb3.rdy_i  = 1'b1;
        for (int k = 0; k < 6; k++) begin
            applyStimulus(5'b11111, 5'b11111, 1'b1);
            checkAll($sformatf("sf.idle%0d", k), 1'b0, (k == 0) ? 0 : (k - 1) % N, 1'b0, 1'b0);
            checkOutput($sformatf("sf3.idle%0d", k), int'(arb3.grant_vld_o), 0);
            tick();
            checkAll($sformatf("sf.lock%0d", k), 1'b1, k % N, 1'b1, 1'b1);
            checkOutput($sformatf("sf3.vld%0d", k), int'(arb3.grant_vld_o), 1);
            checkOutput($sformatf("sf3.grant%0d", k), int'(arb3.grant_o), k % 3);
            checkOutput($sformatf("sf3.done%0d", k), int'(arb3.pkt_done_o), 1);
            tick();
        end
        arb3.req_i  = '0;
        arb3.last_i = '0;
        arb3.rdy_i  = 1'b0;

        // Reset in the middle of a packet drops the lock; search restarts at 0.
        doReset();
        applyStimulus(5'b01000, 5'b00000, 1'b1);
        checkAll("mid.arb", 1'b0, 0, 1'b0, 1'b0);
        tick();
        applyStimulus(5'b01000, 5'b00000, 1'b1);
        checkAll("mid.f1", 1'b1, 3, 1'b1, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        applyStimulus(5'b11000, 5'b00000, 1'b1);
        checkAll("mid.rst", 1'b0, 0, 1'b0, 1'b0);
        tick();
        applyStimulus(5'b11000, 5'b00000, 1'b1);
        checkAll("mid.regrant", 1'b1, 3, 1'b1, 1'b0);
        tick();

        // Randomized traffic against the behavioural model.
        doReset();
        for (int c = 0; c < 600; c++) begin
            logic [N-1:0] q;
            logic [N-1:0] l;
            logic         rd;
            logic         rs;
            q  = ($urandom_range(0, 7) == 0) ? '0 : N'($urandom_range(0, 31));
            for (int b = 0; b < N; b++) l[b] = ($urandom_range(0, 3) == 0);
            rd = ($urandom_range(0, 3) != 0);
            rs = ($urandom_range(0, 99) == 0);
            rst = rs;
            applyStimulus(q, l, rd);
            checkAll($sformatf("rnd%0d", c), mLocked, mGrant,
                     mLocked && rd && q[mGrant],
                     mLocked && rd && q[mGrant] && l[mGrant]);
            tick();
            modelStep(rs, q, l, rd);
        end
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
